// File: rtl/aes_key_expand.sv
// Serial AES-128 key schedule: one S-box lookup per cycle, five cycles per round key.
// Round keys are streamed with rk_valid and kept in an 11-entry register file read by index.
module aes_key_expand (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         done,
  output logic         keys_ready,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
);

  typedef enum logic [1:0] {IDLE, SUB, MIX} state_t;

  // FIPS-197 S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t         state, state_nx;
  logic [127:0]   kreg;
  logic [31:0]    tmp;
  logic [3:0]     round;
  logic [1:0]     k;
  logic [127:0]   rf [0:10];

  logic [31:0]    w3, rot, t;
  logic [31:0]    w4, w5, w6, w7;
  logic [127:0]   new_key;
  logic [7:0]     sbox_in, sbox_out, rcon;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SUB;
      SUB:     if (k == 2'd3) state_nx = MIX;
      MIX:     state_nx = (round == 4'd10) ? IDLE : SUB;
      default: state_nx = IDLE;
    endcase
  end

  assign w3  = kreg[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  always_comb begin
    sbox_in = rot[31:24];
    case (k)
      2'd0: sbox_in = rot[31:24];
      2'd1: sbox_in = rot[23:16];
      2'd2: sbox_in = rot[15:8];
      2'd3: sbox_in = rot[7:0];
      default: sbox_in = rot[31:24];
    endcase
  end

  // Entry x sits at bits 8*(255-x)+7 downto 8*(255-x); 255-x is ~x for a byte.
  assign sbox_out = SBOX_TBL[{~sbox_in, 3'b111} -: 8];

  always_comb begin
    rcon = 8'h00;
    case (round)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t       = tmp ^ {rcon, 24'h000000};
  assign w4      = kreg[127:96] ^ t;
  assign w5      = w4 ^ kreg[95:64];
  assign w6      = w5 ^ kreg[63:32];
  assign w7      = w6 ^ kreg[31:0];
  assign new_key = {w4, w5, w6, w7};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kreg       <= '0;
      tmp        <= '0;
      round      <= '0;
      k          <= '0;
      busy       <= 1'b0;
      rk_valid   <= 1'b0;
      rk_index   <= '0;
      round_key  <= '0;
      done       <= 1'b0;
      keys_ready <= 1'b0;
      for (int i = 0; i < 11; i++) rf[i] <= '0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            kreg       <= key_in;
            rf[0]      <= key_in;
            round_key  <= key_in;
            rk_index   <= 4'd0;
            rk_valid   <= 1'b1;
            round      <= 4'd1;
            k          <= 2'd0;
            busy       <= 1'b1;
            keys_ready <= 1'b0;
          end
        end
        SUB: begin
          case (k)
            2'd0: tmp[31:24] <= sbox_out;
            2'd1: tmp[23:16] <= sbox_out;
            2'd2: tmp[15:8]  <= sbox_out;
            2'd3: tmp[7:0]   <= sbox_out;
            default: tmp[31:24] <= sbox_out;
          endcase
          k <= k + 2'd1;
        end
        MIX: begin
          kreg      <= new_key;
          rf[round] <= new_key;
          round_key <= new_key;
          rk_index  <= round;
          rk_valid  <= 1'b1;
          if (round == 4'd10) begin
            done       <= 1'b1;
            busy       <= 1'b0;
            keys_ready <= 1'b1;
          end else begin
            round <= round + 4'd1;
            k     <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_addr <= 4'd10) rd_key = rf[rd_addr];
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 A.1 and all-zero key schedules,
// ignored start, mid-run reset, held start and read-during-write.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [127:0] key_in;
  logic         busy, rk_valid, done, keys_ready;
  logic [3:0]   rk_index;
  logic [127:0] round_key;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;

  int errors = 0;
  int checks = 0;

  logic [127:0] a1_keys   [11];
  logic [127:0] zero_keys [11];
  logic [127:0] exp_keys  [11];

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_JUNK = 128'hdeadbeef0123456789abcdeffedcba98;

  aes_key_expand dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_index   (rk_index),
    .round_key  (round_key),
    .done       (done),
    .keys_ready (keys_ready),
    .rd_addr    (rd_addr),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one expansion from the current sample point; returns at the sample after edge T+50.
  task automatic run_exp(input logic [127:0] key, input int stray_c, input logic hold_start);
    int pulses;
    start  = 1'b1;
    key_in = key;
    tick();
    if (!hold_start) start = 1'b0;
    pulses = rk_valid ? 1 : 0;
    check("c0_valid", 128'(rk_valid), 128'(1));
    check("c0_index", 128'(rk_index), 128'(0));
    check("c0_key", round_key, exp_keys[0]);
    check("c0_busy", 128'(busy), 128'(1));
    check("c0_ready", 128'(keys_ready), 128'(0));
    for (int c = 1; c <= 50; c++) begin
      if (c == stray_c) begin
        start  = 1'b1;
        key_in = KEY_JUNK;
      end
      tick();
      if (c == stray_c && !hold_start) start = 1'b0;
      if (rk_valid) pulses++;
      check($sformatf("valid_c%0d", c), 128'(rk_valid), 128'(c % 5 == 0));
      if (c % 5 == 0) begin
        check($sformatf("index_c%0d", c), 128'(rk_index), 128'(c / 5));
        check($sformatf("key_r%0d", c / 5), round_key, exp_keys[c / 5]);
      end
      check($sformatf("busy_c%0d", c), 128'(busy), 128'(c < 50));
      check($sformatf("done_c%0d", c), 128'(done), 128'(c == 50));
      check($sformatf("ready_c%0d", c), 128'(keys_ready), 128'(c == 50));
    end
    check("pulse_count", 128'(pulses), 128'(11));
  endtask

  initial begin
    a1_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    zero_keys[0]  = 128'h00000000000000000000000000000000;
    zero_keys[1]  = 128'h62636363626363636263636362636363;
    zero_keys[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    zero_keys[3]  = 128'h90973450696ccffaf2f457330b0fac99;
    zero_keys[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
    zero_keys[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    zero_keys[6]  = 128'hec614b851425758c99ff09376ab49ba7;
    zero_keys[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
    zero_keys[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
    zero_keys[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    zero_keys[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // Reset state
    resetn  = 1'b0;
    start   = 1'b0;
    key_in  = '0;
    rd_addr = 4'd0;
    #23;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(rk_valid), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_ready", 128'(keys_ready), 128'(0));
    check("rst_index", 128'(rk_index), 128'(0));
    check("rst_key", round_key, 128'(0));
    check("rst_rd0", rd_key, 128'(0));
    resetn = 1'b1;
    tick();
    tick();

    // A.1 key with an ignored start at T+20
    exp_keys = a1_keys;
    run_exp(KEY_A1, 20, 1'b0);
    tick();
    check("a1_idle_valid", 128'(rk_valid), 128'(0));
    check("a1_idle_ready", 128'(keys_ready), 128'(1));

    // All-zero key, then read back the whole register file
    exp_keys = zero_keys;
    run_exp(128'h0, -1, 1'b0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check($sformatf("rd_%0d", a), rd_key, (a <= 10) ? zero_keys[a] : 128'h0);
    end
    rd_addr = 4'd0;
    tick();

    // Reset asserted mid-expansion at T+23
    start  = 1'b1;
    key_in = KEY_A1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 23; c++) tick();
    resetn = 1'b0;
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_valid", 128'(rk_valid), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_ready", 128'(keys_ready), 128'(0));
    check("abort_index", 128'(rk_index), 128'(0));
    check("abort_key", round_key, 128'(0));
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check($sformatf("abort_rd_%0d", a), rd_key, 128'h0);
    end
    rd_addr = 4'd0;
    tick();
    check("abort_held_done", 128'(done), 128'(0));
    resetn = 1'b1;
    tick();
    check("abort_idle_busy", 128'(busy), 128'(0));
    exp_keys = a1_keys;
    run_exp(KEY_A1, -1, 1'b0);
    tick();

    // start held high: zero key, then A.1 accepted at T+51
    exp_keys = zero_keys;
    run_exp(128'h0, -1, 1'b1);
    key_in = KEY_A1;
    tick();
    check("hold_restart_valid", 128'(rk_valid), 128'(1));
    check("hold_restart_index", 128'(rk_index), 128'(0));
    check("hold_restart_key", round_key, a1_keys[0]);
    check("hold_restart_busy", 128'(busy), 128'(1));
    check("hold_restart_ready", 128'(keys_ready), 128'(0));
    for (int c = 1; c <= 14; c++) tick();
    rd_addr = 4'd3;
    #1;
    check("rdw_old", rd_key, zero_keys[3]);
    tick();
    check("rdw_index", 128'(rk_index), 128'(3));
    check("rdw_new", rd_key, a1_keys[3]);
    for (int c = 16; c <= 50; c++) begin
      tick();
      if (c < 50) check($sformatf("hold_ready_c%0d", c), 128'(keys_ready), 128'(0));
    end
    check("hold_done", 128'(done), 128'(1));
    check("hold_key10", round_key, a1_keys[10]);
    start = 1'b0;
    tick();
    check("hold_end_ready", 128'(keys_ready), 128'(1));
    check("hold_end_busy", 128'(busy), 128'(0));
    check("hold_end_valid", 128'(rk_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Serial AES-128 key-schedule engine that turns a 128-bit cipher key into the 11 round keys (FIPS-197 KeyExpansion). It uses one 8-bit EncryptionSBOX instance, so SubWord takes four cycles, one byte per cycle. Every round key is streamed out with a valid strobe and also stored in an internal 11-entry register file, which the downstream round datapath reads by index. The block sits between the key-load interface and the encryption round core.

## Interface
- No parameters. AES-128 only (Nk=4, Nr=10).
- clk  in  1  rising-edge clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- key_in  in  128  cipher key, captured on the accepted start edge; key_in[127:96] = w0.
- busy  out  1  high from the accepted start edge through the edge that writes round key 10.
- rk_valid  out  1  one-cycle pulse for each round key produced.
- rk_index  out  4  round number (0..10) of round_key; valid with rk_valid.
- round_key  out  128  most recently produced round key.
- done  out  1  one-cycle pulse, coincident with the rk_valid for round 10.
- keys_ready  out  1  high once all 11 keys are stored; cleared by an accepted start or by reset.
- rd_addr  in  4  register-file read index.
- rd_key  out  128  combinational read of entry rd_addr; 0 if rd_addr > 10.

## Operation
- States: IDLE, SUB, MIX.
- IDLE + start=1 at edge T:
  - kreg <= key_in; rf[0] <= key_in.
  - round_key <= key_in; rk_index <= 0; rk_valid <= 1.
  - round <= 1; byte counter k <= 0; busy <= 1; keys_ready <= 0.
  - Next state SUB.
- SUB (4 cycles, k=0..3):
  - rot = {w3[23:0], w3[31:24]}, where w3 = kreg[31:0].
  - The S-box input is byte k of rot, MSB first (k=0 → rot[31:24]).
  - The output is registered into tmp byte k.
  - At k=3, go to MIX.
- MIX (1 cycle):
  - t = tmp ^ {rcon[round], 24'h0}.
  - w4 = w0^t, w5 = w4^w1, w6 = w5^w2, w7 = w6^w3.
  - kreg, rf[round] and round_key all <= {w4,w5,w6,w7}.
  - rk_index <= round; rk_valid <= 1.
  - If round==10: done <= 1, busy <= 0, keys_ready <= 1, go to IDLE.
  - Otherwise: round += 1, k <= 0, go to SUB.
- rcon for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- All XORs are 32-bit bitwise; no carries.
- start is ignored while busy; it is not queued.
- start in the same cycle as a done edge is ignored, since the FSM is still in MIX.
- Register file is written only in IDLE→SUB (entry 0) and in MIX; reads are unaffected by state.

## Timing
- Reset values (all asynchronous):
  - Outputs: busy=0, rk_valid=0, done=0, keys_ready=0, rk_index=0, round_key=0.
  - Internal: state=IDLE, all rf entries = 0.
- Round key r appears at edge T+5r; round 10 and done appear at edge T+50.
- busy is high for 50 cycles (T .. T+49 inclusive, low after T+50).
- Next start is accepted at edge T+51 at the earliest.
- rd_key is combinational on rd_addr. A read of an entry being written in the same cycle returns the old value; the new value is visible the cycle after the write edge.
- resetn low mid-expansion: immediate abort. All outputs go to reset values, rf is cleared, and no done pulse is emitted. After release, the block waits in IDLE for a new start.
- Restarting with a new start after completion overwrites rf progressively. keys_ready stays 0 until the new done.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c → expected response:
  - rk_index 0 = same key at T.
  - Round 1 = a0fafe1788542cb123a339392a6c7605 at T+5.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at T+50, with done=1 on that cycle.
- All-zero key → expected response:
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Afterwards, rd_addr 0..10 returns each stored key; rd_addr 11..15 returns 0.
- start pulsed at T+20 with a different key_in during the A.1 run → ignored; A.1 outputs unchanged and exactly 11 rk_valid pulses.
- resetn asserted at T+23 → expected response:
  - All outputs 0 immediately; rd_key = 0 for every address.
  - A new start on A.1 then completes normally at T'+50.
- start held high continuously from T → exactly one expansion per 51 cycles:
  - done at T+50.
  - Next accepted start at T+51, which clears keys_ready.
- Read-during-write: rd_addr=3 during the second expansion's MIX for round 3 → old key that cycle, new key the next cycle.
